// File: rtl/datapath_register_bank.sv
// Processor datapath register bank: AR, R, PC, IR, RL, RC, RP, RQ, R1, AC, Z flag and the internal bus mux.
// Optional sticky increment-wrap flags on PC/RC/RP/RQ when REG_BANK_INC_OVF_EN is defined.
module datapath_register_bank #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned IR_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            wrEnReg,
    input  logic [3:0]            incReg,
    input  logic [3:0]            busSel,
    input  logic                  ZWrEn,
    input  logic [DATA_WIDTH-1:0] aluOut,
    input  logic [DATA_WIDTH-1:0] insMemData,
    input  logic [DATA_WIDTH-1:0] dataMemData,
    output logic [DATA_WIDTH-1:0] bus,
    output logic [IR_WIDTH-1:0]   ins,
    output logic                  Zout,
    output logic [ADDR_WIDTH-1:0] insAddr,
    output logic [ADDR_WIDTH-1:0] dataAddr,
    output logic [DATA_WIDTH-1:0] dataMemWrData,
    output logic [DATA_WIDTH-1:0] acOut
`ifdef REG_BANK_INC_OVF_EN
    ,
    output logic [3:0]            incOvf
`endif
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] ar_q, ar_d;
    logic [DATA_WIDTH-1:0] r_q,  r_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [DATA_WIDTH-1:0] rl_q, rl_d;
    logic [DATA_WIDTH-1:0] rc_q, rc_d;
    logic [DATA_WIDTH-1:0] rp_q, rp_d;
    logic [DATA_WIDTH-1:0] rq_q, rq_d;
    logic [DATA_WIDTH-1:0] r1_q, r1_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic                  z_q,  z_d;

    always_comb begin
        bus = '0;
        unique case (busSel)
            4'd1:    bus = insMemData;
            4'd2:    bus = dataMemData;
            4'd3:    bus = pc_q;
            4'd4:    bus = DATA_WIDTH'(ir_q);
            4'd5:    bus = rl_q;
            4'd6:    bus = rc_q;
            4'd7:    bus = rp_q;
            4'd8:    bus = rq_q;
            4'd9:    bus = r1_q;
            4'd10:   bus = ac_q;
            4'd11:   bus = r_q;
            default: bus = '0;
        endcase
    end

    // A write to an incrementable register takes priority over its increment.
    always_comb begin
        ar_d = wrEnReg[9] ? bus : ar_q;
        r_d  = wrEnReg[8] ? bus : r_q;
        ir_d = wrEnReg[6] ? bus[IR_WIDTH-1:0] : ir_q;
        rl_d = wrEnReg[5] ? bus : rl_q;
        r1_d = wrEnReg[1] ? bus : r1_q;
        ac_d = wrEnReg[0] ? aluOut : ac_q;
        z_d  = ZWrEn ? (aluOut == '0) : z_q;

        pc_d = pc_q;
        if (wrEnReg[7])     pc_d = bus;
        else if (incReg[3]) pc_d = pc_q + ONE;

        rc_d = rc_q;
        if (wrEnReg[4])     rc_d = bus;
        else if (incReg[2]) rc_d = rc_q + ONE;

        rp_d = rp_q;
        if (wrEnReg[3])     rp_d = bus;
        else if (incReg[1]) rp_d = rp_q + ONE;

        rq_d = rq_q;
        if (wrEnReg[2])     rq_d = bus;
        else if (incReg[0]) rq_d = rq_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= '0;
            r_q  <= '0;
            pc_q <= '0;
            ir_q <= '0;
            rl_q <= '0;
            rc_q <= '0;
            rp_q <= '0;
            rq_q <= '0;
            r1_q <= '0;
            ac_q <= '0;
            z_q  <= 1'b0;
        end else begin
            ar_q <= ar_d;
            r_q  <= r_d;
            pc_q <= pc_d;
            ir_q <= ir_d;
            rl_q <= rl_d;
            rc_q <= rc_d;
            rp_q <= rp_d;
            rq_q <= rq_d;
            r1_q <= r1_d;
            ac_q <= ac_d;
            z_q  <= z_d;
        end
    end

`ifdef REG_BANK_INC_OVF_EN
    logic [3:0] ovf_q, ovf_d;
    logic [3:0] inc_eff;
    logic [3:0] at_max;

    always_comb begin
        inc_eff = incReg & ~{wrEnReg[7], wrEnReg[4], wrEnReg[3], wrEnReg[2]};
        at_max  = {pc_q == '1, rc_q == '1, rp_q == '1, rq_q == '1};
        ovf_d   = ovf_q | (inc_eff & at_max);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign incOvf = ovf_q;
`endif

    assign ins           = ir_q;
    assign Zout          = z_q;
    assign insAddr       = pc_q[ADDR_WIDTH-1:0];
    assign dataAddr      = ar_q[ADDR_WIDTH-1:0];
    assign dataMemWrData = ac_q;
    assign acOut         = ac_q;

endmodule

// File: tb/tb_datapath_register_bank.sv
// Directed self-checking bench for datapath_register_bank (also covers REG_BANK_INC_OVF_EN when defined).
module tb_datapath_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  wrEnReg;
    logic [3:0]  incReg;
    logic [3:0]  busSel;
    logic        ZWrEn;
    logic [11:0] aluOut;
    logic [11:0] insMemData;
    logic [11:0] dataMemData;
    logic [11:0] bus;
    logic [7:0]  ins;
    logic        Zout;
    logic [7:0]  insAddr;
    logic [7:0]  dataAddr;
    logic [11:0] dataMemWrData;
    logic [11:0] acOut;
`ifdef REG_BANK_INC_OVF_EN
    logic [3:0]  incOvf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_register_bank #(
        .DATA_WIDTH(12),
        .IR_WIDTH  (8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrEnReg      (wrEnReg),
        .incReg       (incReg),
        .busSel       (busSel),
        .ZWrEn        (ZWrEn),
        .aluOut       (aluOut),
        .insMemData   (insMemData),
        .dataMemData  (dataMemData),
        .bus          (bus),
        .ins          (ins),
        .Zout         (Zout),
        .insAddr      (insAddr),
        .dataAddr     (dataAddr),
        .dataMemWrData(dataMemWrData),
        .acOut        (acOut)
`ifdef REG_BANK_INC_OVF_EN
        ,
        .incOvf       (incOvf)
`endif
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply the current control word at one rising edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        wrEnReg = '0;
        incReg  = '0;
        busSel  = '0;
        ZWrEn   = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [3:0] sel, input logic [11:0] exp);
        busSel = sel;
        #1;
        chk(tag, bus, exp);
        busSel = '0;
    endtask

    initial begin
        rst = 1'b0; wrEnReg = '0; incReg = '0; busSel = '0; ZWrEn = 1'b0;
        aluOut = '0; insMemData = '0; dataMemData = '0;

        // Load every register with nonzero values
        busSel = 4'd1; insMemData = 12'hABC; wrEnReg = 10'b1111111111; aluOut = 12'h5A5;
        tick();
        aluOut = 12'h000; ZWrEn = 1'b1;
        tick();
        rdchk("pre_rl", 4'd5, 12'hABC);
        chk("pre_ins", 12'(ins), 12'h0BC);
        chk("pre_ac", acOut, 12'h5A5);
        chk("pre_z", 12'(Zout), 12'h001);

        // Reset overrides all enables in the same cycle
        rst = 1'b1; busSel = 4'd1; insMemData = 12'h777; wrEnReg = '1; incReg = '1;
        ZWrEn = 1'b1; aluOut = 12'h000;
        tick();
        rdchk("rst_pc", 4'd3, 12'h000);
        rdchk("rst_ir", 4'd4, 12'h000);
        rdchk("rst_rl", 4'd5, 12'h000);
        rdchk("rst_rc", 4'd6, 12'h000);
        rdchk("rst_rp", 4'd7, 12'h000);
        rdchk("rst_rq", 4'd8, 12'h000);
        rdchk("rst_r1", 4'd9, 12'h000);
        rdchk("rst_ac", 4'd10, 12'h000);
        rdchk("rst_r", 4'd11, 12'h000);
        chk("rst_dataAddr", 12'(dataAddr), 12'h000);
        chk("rst_ins", 12'(ins), 12'h000);
        chk("rst_z", 12'(Zout), 12'h000);
`ifdef REG_BANK_INC_OVF_EN
        chk("rst_ovf", 12'(incOvf), 12'h000);
`endif

        // Fetch path
        insMemData = 12'h00B; busSel = 4'd1; wrEnReg = 10'b0001000000;
        tick();
        chk("fetch_ins", 12'(ins), 12'h00B);
        rdchk("fetch_ir_zext", 4'd4, 12'h00B);
        chk("fetch_pc0", 12'(insAddr), 12'h000);
        incReg = 4'b1000;
        tick();
        chk("fetch_pc1", 12'(insAddr), 12'h001);

        // Load/store path and Z flag
        busSel = 4'd1; insMemData = 12'h123; wrEnReg = 10'b1000000000;
        tick();
        chk("ar_load", 12'(dataAddr), 12'h023);
        aluOut = 12'h000; wrEnReg = 10'b0000000001; ZWrEn = 1'b1;
        tick();
        chk("ac_zero", acOut, 12'h000);
        chk("wrdata_zero", dataMemWrData, 12'h000);
        chk("z_set", 12'(Zout), 12'h001);
        aluOut = 12'h005; wrEnReg = 10'b0000000001;
        tick();
        chk("ac_five", acOut, 12'h005);
        chk("z_hold", 12'(Zout), 12'h001);
        aluOut = 12'h005; ZWrEn = 1'b1;
        tick();
        chk("z_clear", 12'(Zout), 12'h000);
        dataMemData = 12'h3C3;
        rdchk("bus_datamem", 4'd2, 12'h3C3);

        // Concurrent increments with wrap
        busSel = 4'd1; insMemData = 12'hFFF; wrEnReg = 10'b0000011100;
        tick();
        incReg = 4'b0111;
        tick();
        rdchk("wrap_rc", 4'd6, 12'h000);
        rdchk("wrap_rp", 4'd7, 12'h000);
        rdchk("wrap_rq", 4'd8, 12'h000);
        rdchk("wrap_pc_idle", 4'd3, 12'h001);
`ifdef REG_BANK_INC_OVF_EN
        chk("wrap_ovf", 12'(incOvf), 12'h007);
`endif

        // Write/increment conflict: write wins, no overflow flag
        busSel = 4'd1; insMemData = 12'hFFF; wrEnReg = 10'b0010000000;
        tick();
        busSel = 4'd1; insMemData = 12'h040; wrEnReg = 10'b0010000000; incReg = 4'b1000;
        tick();
        rdchk("conflict_pc", 4'd3, 12'h040);
`ifdef REG_BANK_INC_OVF_EN
        chk("conflict_ovf", 12'(incOvf), 12'h007);
`endif
        busSel = 4'd1; insMemData = 12'h005; wrEnReg = 10'b0010000000;
        tick();
        busSel = 4'd1; insMemData = 12'h040; wrEnReg = 10'b0010000000; incReg = 4'b1000;
        tick();
        rdchk("conflict_pc5", 4'd3, 12'h040);
        incReg = 4'b1000;
        tick();
        rdchk("inc_pc", 4'd3, 12'h041);

        // Multi-write and self-transfer
        busSel = 4'd1; insMemData = 12'h007; wrEnReg = 10'b0000100000;
        tick();
        busSel = 4'd5; wrEnReg = 10'b0000100110;
        tick();
        rdchk("multi_rl", 4'd5, 12'h007);
        rdchk("multi_rq", 4'd8, 12'h007);
        rdchk("multi_r1", 4'd9, 12'h007);
        busSel = 4'd1; insMemData = 12'h222; wrEnReg = 10'b0000001000;
        tick();
        rdchk("rp_load", 4'd7, 12'h222);
        busSel = 4'd13; wrEnReg = 10'b0000001000;
        tick();
        rdchk("rp_unused_sel", 4'd7, 12'h000);
        rdchk("bus_sel15", 4'd15, 12'h000);
        rdchk("bus_sel0", 4'd0, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_register_bank.md
Name: datapath_register_bank

Overview:
- Datapath register file of one processor core; directly consumes the control unit's per-cycle control word (wrEnReg, incReg, busSel, ZWrEn).
- Holds AR, R, PC, IR, RL, RC, RP, RQ, R1, AC and the Z flag.
- Drives the shared internal bus, feeds the instruction register back to the control unit as `ins`, and feeds the Z flag back as `Zout`.
- Supplies addresses and write data to instruction and data memory, and the AC and bus operands to the ALU.

Parameters:
- DATA_WIDTH, 12, width of the bus and of AR, R, PC, RL, RC, RP, RQ, R1, AC.
- IR_WIDTH, 8, width of IR and `ins`; must be <= DATA_WIDTH.
- ADDR_WIDTH, 8, width of insAddr and dataAddr; must be <= DATA_WIDTH.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wrEnReg  in  10  write enables {AR, R, PC, IR, RL, RC, RP, RQ, R1, AC}.
- incReg  in  4  increment enables {PC, RC, RP, RQ}.
- busSel  in  4  bus source select (encoding below).
- ZWrEn  in  1  load Z flag from aluOut.
- aluOut  in  DATA_WIDTH  ALU result.
- insMemData  in  DATA_WIDTH  instruction memory read word.
- dataMemData  in  DATA_WIDTH  data memory read word.
- bus  out  DATA_WIDTH  current bus value (combinational).
- ins  out  IR_WIDTH  IR contents, to control unit.
- Zout  out  1  Z flag, to control unit.
- insAddr  out  ADDR_WIDTH  PC[ADDR_WIDTH-1:0].
- dataAddr  out  ADDR_WIDTH  AR[ADDR_WIDTH-1:0].
- dataMemWrData  out  DATA_WIDTH  AC (write data for STR).
- acOut  out  DATA_WIDTH  AC, ALU operand A.

Behaviour:
- Reset:
  - rst=1 at a rising edge clears every register and Z to 0, overriding all enables in that cycle.
  - Reset mid-instruction discards that cycle's writes and increments.
- Bus mux, combinational:
  - busSel 0 → 0; 1 → insMemData; 2 → dataMemData; 3 → PC; 4 → IR zero-extended; 5 → RL; 6 → RC; 7 → RP; 8 → RQ; 9 → R1; 10 → AC; 11 → R.
  - Codes 12–15 → 0.
- Writes:
  - AR, R, PC, RL, RC, RP, RQ, R1 load `bus` when their enable bit is set.
  - IR loads bus[IR_WIDTH-1:0].
  - AC loads aluOut, not bus.
  - Multiple enable bits may be set together; every enabled register loads the same bus value in that cycle.
- Increments:
  - Each register with its incReg bit set becomes reg+1, modulo 2^DATA_WIDTH; all-ones wraps to 0.
  - PC, RC, RP, RQ increment independently, and any combination may be set (e.g. 0111).
- Conflict: wrEnReg and incReg set for the same register in one cycle → the write wins and the increment is dropped.
- Self-transfer: a register selected onto the bus and written in the same cycle loads its own pre-edge value, i.e. no change.
- Z flag: ZWrEn=1 loads Z = (aluOut == 0); otherwise Z holds.
- Latency: every write, increment or Z update is visible on outputs in the cycle after the edge; bus and all outputs reflect registered state combinationally.
- No handshake: the block obeys the control word every cycle and never stalls.

Optional Feature:
- Macro REG_BANK_INC_OVF_EN.
- Defined: adds output `incOvf` [3:0] {PC, RC, RP, RQ}, one sticky bit per increment register.
  - A bit sets when its register wraps from all-ones to 0 through an increment.
  - Bits clear only on rst.
  - An increment dropped because of a write conflict does not set its bit.
- Undefined: no port and no logic; behaviour is otherwise identical.

Test Plan:
- Reset: load all registers with nonzero values, then assert rst for 1 cycle → all registers 0, Zout=0, ins=0 on the next cycle.
- Fetch path: insMemData=0x00B, busSel=1, wrEnReg=0001000000 → ins=8'h0B; then incReg=1000 → insAddr increments 0→1.
- Bus and load/store path: busSel=1, insMemData=0x123, wrEnReg=1000000000 → dataAddr=0x23 next cycle; then aluOut=0x0, wrEnReg=0000000001, ZWrEn=1 → acOut=0, dataMemWrData=0, Zout=1.
- Concurrent increments: RC=RP=RQ=0xFFF, incReg=0111 → all three read 0x000; with REG_BANK_INC_OVF_EN defined, incOvf=0111.
- Write/increment conflict: PC=5, busSel=1, insMemData=0x40, wrEnReg=0010000000, incReg=1000 → PC=0x40, not 0x41; with REG_BANK_INC_OVF_EN defined and PC=0xFFF beforehand, incOvf[3] stays 0.
- Multi-write and self-transfer: RL=0x7, busSel=5, wrEnReg=0000100110 → RL=RQ=R1=0x7, RL unchanged; busSel=13 with RP write enabled → RP=0.
